// File: rtl/pci_master_initiator.sv
// PCI bus initiator: turns a command/address/length request into a PCI
// Memory Read or Memory Write transaction with waits, master abort and turnaround.
`timescale 1ns/1ps
module pci_master_initiator #(
   parameter int LEN_W          = 4,
   parameter int DEVSEL_TIMEOUT = 5
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             REQ,
   input  logic             CMD_WR,
   input  logic [31:0]      ADDR,
   input  logic [LEN_W-1:0] LEN,
   input  logic [31:0]      WDATA,
   output logic             WDATA_ACK,
   output logic [31:0]      RDATA,
   output logic             RDATA_VLD,
   output logic             BUSY,
   output logic             DONE,
   output logic             ERR,
   output logic             FRAME_N,
   output logic             IRDY_N,
   output logic [3:0]       CBE,
   inout  wire  [31:0]      AD,
   input  logic             TRDY_N,
   input  logic             DEVSEL_N
);

   localparam int         TO_W       = $clog2(DEVSEL_TIMEOUT + 1);
   localparam logic [3:0] CBE_MEM_RD = 4'b0110;
   localparam logic [3:0] CBE_MEM_WR = 4'b0111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_ABORT,
      S_TURN
   } state_e;

   state_e           state_q, state_d;
   logic             cmd_wr_q, cmd_wr_d;
   logic [31:0]      addr_q, addr_d;
   logic [LEN_W-1:0] beats_q, beats_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic             dev_seen_q, dev_seen_d;
   logic             err_flag_q, err_flag_d;
   logic             frame_n_q, frame_n_d;
   logic             irdy_n_q, irdy_n_d;
   logic [3:0]       cbe_q, cbe_d;
   logic             ad_oe_q, ad_oe_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             rdata_vld_q, rdata_vld_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;
   logic             beat_done;

   assign beat_done = (state_q == S_DATA) && !irdy_n_q && !TRDY_N && !DEVSEL_N;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
      state_d     = state_q;
      cmd_wr_d    = cmd_wr_q;
      addr_d      = addr_q;
      beats_d     = beats_q;
      to_cnt_d    = to_cnt_q;
      dev_seen_d  = dev_seen_q;
      err_flag_d  = err_flag_q;
      rdata_d     = rdata_q;
      rdata_vld_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (REQ) begin
               cmd_wr_d   = CMD_WR;
               addr_d     = ADDR;
               beats_d    = (LEN == '0) ? LEN_W'(1) : LEN;
               err_flag_d = 1'b0;
               state_d    = S_ADDR;
            end
         end
         S_ADDR: begin
            to_cnt_d   = '0;
            dev_seen_d = 1'b0;
            state_d    = S_DATA;
         end
         S_DATA: begin
            if (!DEVSEL_N) dev_seen_d = 1'b1;
            if (beat_done) begin
               if (beats_q != '0) beats_d = beats_q - LEN_W'(1);
               if (!cmd_wr_q) begin
                  rdata_d     = AD;
                  rdata_vld_d = 1'b1;
               end
               if (beats_q <= LEN_W'(1)) state_d = S_TURN;
            end else if (!dev_seen_q && DEVSEL_N) begin
               // Timeout only runs until the target has claimed the cycle once.
               to_cnt_d = to_cnt_q + TO_W'(1);
               if (to_cnt_d == TO_W'(DEVSEL_TIMEOUT)) state_d = S_ABORT;
            end
         end
         S_ABORT: begin
            err_flag_d = 1'b1;
            state_d    = S_TURN;
         end
         S_TURN:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Bus outputs are registered, so they are derived from the state being entered.
      frame_n_d = 1'b1;
      irdy_n_d  = 1'b1;
      cbe_d     = 4'hF;
      ad_oe_d   = 1'b0;
      case (state_d)
         S_ADDR: begin
            frame_n_d = 1'b0;
            cbe_d     = cmd_wr_d ? CBE_MEM_WR : CBE_MEM_RD;
            ad_oe_d   = 1'b1;
         end
         S_DATA: begin
            frame_n_d = (beats_d == LEN_W'(1));
            irdy_n_d  = 1'b0;
            cbe_d     = 4'b0000;
            ad_oe_d   = cmd_wr_d;
         end
         S_ABORT: begin
            irdy_n_d = 1'b0;
            cbe_d    = 4'b0000;
         end
         default: ;
      endcase

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_TURN);
      err_d  = done_d && err_flag_d;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= S_IDLE;
         cmd_wr_q    <= 1'b0;
         addr_q      <= '0;
         beats_q     <= '0;
         to_cnt_q    <= '0;
         dev_seen_q  <= 1'b0;
         err_flag_q  <= 1'b0;
         frame_n_q   <= 1'b1;
         irdy_n_q    <= 1'b1;
         cbe_q       <= 4'hF;
         ad_oe_q     <= 1'b0;
         rdata_q     <= '0;
         rdata_vld_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         state_q     <= state_d;
         cmd_wr_q    <= cmd_wr_d;
         addr_q      <= addr_d;
         beats_q     <= beats_d;
         to_cnt_q    <= to_cnt_d;
         dev_seen_q  <= dev_seen_d;
         err_flag_q  <= err_flag_d;
         frame_n_q   <= frame_n_d;
         irdy_n_q    <= irdy_n_d;
         cbe_q       <= cbe_d;
         ad_oe_q     <= ad_oe_d;
         rdata_q     <= rdata_d;
         rdata_vld_q <= rdata_vld_d;
         done_q      <= done_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
      end
   end

   // Write data comes straight from the held WDATA word, so the acknowledge fires
   // in the completing cycle and the user can present the next word at that edge.
   assign AD        = ad_oe_q ? ((state_q == S_DATA) ? WDATA : addr_q) : 'z;
   assign WDATA_ACK = beat_done && cmd_wr_q;
   assign RDATA     = rdata_q;
   assign RDATA_VLD = rdata_vld_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign ERR       = err_q;
   assign FRAME_N   = frame_n_q;
   assign IRDY_N    = irdy_n_q;
   assign CBE       = cbe_q;

endmodule

// File: doc/pci_master_initiator.md
Name: pci_master_initiator

Overview:
PCI bus initiator that sits directly upstream of the PCI target device. It drives FRAME_N, IRDY_N, CBE and AD to the target and consumes TRDY_N and DEVSEL_N from it. It turns a simple user request (command, address, beat count) into a complete PCI transaction: address phase, data phase(s), wait states, master abort and turnaround. Memory Read (4'b0110) and Memory Write (4'b0111) only.

Parameters:
LEN_W, 4, width of the burst-length field (max burst 2^LEN_W-1 beats)
DEVSEL_TIMEOUT, 5, cycles after the address phase to wait for DEVSEL_N before a master abort

Ports:
CLK  input  1  bus clock, all logic on the rising edge
RST  input  1  synchronous, active-high reset
REQ  input  1  start-request pulse; sampled only when BUSY=0
CMD_WR  input  1  1=Memory Write (CBE 0111), 0=Memory Read (CBE 0110)
ADDR  input  32  transaction address, latched on an accepted REQ
LEN  input  LEN_W  beat count, latched on an accepted REQ; 0 is treated as 1
WDATA  input  32  current write word; must be held until WDATA_ACK
WDATA_ACK  output  1  one-cycle pulse: the current write beat completed
RDATA  output  32  captured read word
RDATA_VLD  output  1  one-cycle pulse: RDATA is valid
BUSY  output  1  transaction in progress
DONE  output  1  one-cycle pulse at the end of a transaction
ERR  output  1  one-cycle pulse with DONE on a master abort
FRAME_N  output  1  PCI FRAME#, active low
IRDY_N  output  1  PCI IRDY#, active low
CBE  output  4  command in the address phase, byte enables (4'b0000) in data phases
AD  inout  32  multiplexed address/data; high-Z when not driven
TRDY_N  input  1  target ready, active low
DEVSEL_N  input  1  device select, active low

Behaviour:
- Reset (RST=1 at an edge, at any time including mid-burst): state IDLE; FRAME_N=1, IRDY_N=1, CBE=4'hF, AD released (high-Z); BUSY, DONE, ERR, WDATA_ACK, RDATA_VLD = 0; RDATA=0; counters cleared. No completion pulse is issued for an aborted transaction.
- All bus outputs and AD output-enable are registered. States: IDLE, ADDR, DATA, ABORT, TURN.
- IDLE: on REQ=1, latch CMD_WR/ADDR/LEN into registers, set BUSY=1, go to ADDR. REQ while BUSY=1 is ignored.
- ADDR (exactly 1 cycle): FRAME_N=0, AD=latched ADDR, CBE=command. Clear the timeout counter. Go to DATA.
- DATA: IRDY_N=0, CBE=4'b0000.
  - Write: AD driven with WDATA.
  - Read: AD released. The first read data cycle serves as the turnaround.
  - FRAME_N=1 in the same cycle IRDY_N=0 for the final beat (beats_left==1); otherwise FRAME_N=0.
- Beat completes at an edge where IRDY_N=0, TRDY_N=0 and DEVSEL_N=0.
  - Write: pulse WDATA_ACK.
  - Read: RDATA<=AD and pulse RDATA_VLD.
  - beats_left decrements.
  - On the final beat, go to TURN.
- Wait state (TRDY_N=1): hold IRDY_N, FRAME_N, CBE and AD unchanged. No pulses.
- DEVSEL timeout: count cycles from the first DATA cycle while DEVSEL_N=1. If the count reaches DEVSEL_TIMEOUT, go to ABORT. Once DEVSEL_N is seen low, the timeout is disabled for the rest of the transaction.
- ABORT (1 cycle): FRAME_N=1, IRDY_N=0, AD released. Go to TURN with ERR flagged.
- TURN (1 cycle): FRAME_N=1, IRDY_N=1, CBE=4'hF, AD released. Pulse DONE (and ERR if flagged), clear BUSY, go to IDLE.
- A new REQ is accepted the cycle after DONE at the earliest.
- beats_left is LEN_W wide and never wraps: it is loaded with max(LEN,1) and stops at 0.

Test Plan:
1. Single write: REQ, CMD_WR=1, ADDR=0x0000FFFF, LEN=1, WDATA=0x0000F0F0; target asserts DEVSEL_N/TRDY_N low in the first data cycle. Required: cycle1 FRAME_N=0, AD=0x0000FFFF, CBE=0111; cycle2 IRDY_N=0, FRAME_N=1, AD=0x0000F0F0, CBE=0000, WDATA_ACK at the edge; cycle3 TURN with AD=Z; DONE=1, ERR=0.
2. Burst read: LEN=3, CMD_WR=0, ADDR=0x100; target returns 0xA1, 0xA2, 0xA3 with no waits. Required: AD=Z in all data cycles; three RDATA_VLD pulses with RDATA=0xA1, 0xA2, 0xA3; FRAME_N=1 only in the third data cycle; DONE after TURN.
3. Wait states: single write with TRDY_N=1 for 2 cycles, then 0. Required: IRDY_N=0 and AD=WDATA held for 3 cycles; exactly one WDATA_ACK; DONE 1 cycle after completion.
4. Master abort: DEVSEL_N stays 1 for a read with LEN=2. Required: after 5 data cycles ABORT (FRAME_N=1, IRDY_N=0), then TURN (IRDY_N=1); DONE=ERR=1; no RDATA_VLD.
5. Reset mid-burst: RST=1 during beat 2 of a LEN=4 write. Required: at the next edge FRAME_N=IRDY_N=1, AD=Z, BUSY=0, no DONE; a fresh REQ then works normally.
6. REQ while BUSY during a LEN=2 read. Required: the second REQ is ignored, the latched ADDR is unchanged, and only one DONE occurs.
